// File: rtl/spi_pkg.sv
// spi_pkg: shared SPI state encoding and word-length constants.
// Shared between the SPI follower and the existing SPI controller.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    WAIT_CS_HIGH = 2'd1,
    ACTIVE       = 2'd2
  } spi_state_t;

  localparam int LEN8  = 8;
  localparam int LEN16 = 16;

  function automatic logic [4:0] word_len(input logic len16);
    return len16 ? 5'(LEN16) : 5'(LEN8);
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: multi-flop pin synchronizer with rise/fall pulses.
// Pulses are combinational from the synchronized level and its delayed copy.
module spi_sync_edge
  import spi_pkg::*;
#(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  localparam int N = (STAGES < 2) ? 2 : STAGES;

  logic [N-1:0] sync_q, sync_d;
  logic         prev_q, prev_d;

  // next values: shift the pin in, remember last synchronized level
  always_comb begin
    sync_d = {sync_q[N-2:0], d};
    prev_d = sync_q[N-1];
  end

  // synchronizer chain and edge-history flop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= {N{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign q    = sync_q[N-1];
  assign rise = q & ~prev_q;
  assign fall = ~q & prev_q;

endmodule

// File: rtl/spi_follower.sv
// spi_follower: SPI follower with one-word TX holding register.
// Pins are synchronized into clk; all SPI modes, 8/16-bit words.
module spi_follower
  import spi_pkg::*;
#(
  parameter int          SYNC_STAGES = 2,
  parameter logic [15:0] TX_FILL     = 16'hFFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cfg_len,
  input  logic        cfg_cpol,
  input  logic        cfg_cpha,
  input  logic        sclk,
  input  logic        cs_n,
  input  logic        mosi,
  output logic        miso,
  output logic        miso_oe,
  input  logic [15:0] tx_data,
  input  logic        tx_valid,
  output logic        tx_ready,
  output logic [15:0] rx_data,
  output logic        rx_valid,
  output logic        busy,
  output logic        tx_underrun,
  output logic        frame_abort
);

  localparam int N = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
  localparam logic [7:0] FLUSH = 8'(N + 1);

  logic sclk_s, sclk_rise, sclk_fall;
  logic cs_s, cs_rise, cs_fall;
  logic [N-1:0] mosi_sync_q, mosi_sync_d;
  logic mosi_s;

  spi_sync_edge #(
    .STAGES  (N),
    .RST_VAL (1'b0)
  ) u_sclk_sync (
    .clk  (clk),
    .rst  (rst),
    .d    (sclk),
    .q    (sclk_s),
    .rise (sclk_rise),
    .fall (sclk_fall)
  );

  spi_sync_edge #(
    .STAGES  (N),
    .RST_VAL (1'b1)
  ) u_cs_sync (
    .clk  (clk),
    .rst  (rst),
    .d    (cs_n),
    .q    (cs_s),
    .rise (cs_rise),
    .fall (cs_fall)
  );

  spi_state_t  state_q, state_d;
  logic        len16_q, len16_d;
  logic        cpol_q, cpol_d;
  logic        cpha_q, cpha_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        first_q, first_d;
  logic        pend_q, pend_d;
  logic [15:0] tx_sh_q, tx_sh_d;
  logic [14:0] rx_sh_q, rx_sh_d;
  logic [15:0] hold_q, hold_d;
  logic        hold_full_q, hold_full_d;
  logic [15:0] rx_data_q, rx_data_d;
  logic        rx_valid_q, rx_valid_d;
  logic        underrun_q, underrun_d;
  logic        abort_q, abort_d;
  logic [7:0]  flush_q, flush_d;

  logic        sclk_edge, lead, trail, smp_edge, shf_edge;
  logic        move, move_len16, accept;
  logic [15:0] rx_new;
  logic [4:0]  cnt_inc;

  assign mosi_sync_d = {mosi_sync_q[N-2:0], mosi};
  assign mosi_s      = mosi_sync_q[N-1];

  assign sclk_edge = sclk_rise | sclk_fall;
  assign lead      = sclk_edge & (sclk_s ^ cpol_q);
  assign trail     = sclk_edge & ~(sclk_s ^ cpol_q);
  assign smp_edge  = cpha_q ? trail : lead;
  assign shf_edge  = cpha_q ? lead : trail;
  assign accept    = tx_valid & ~hold_full_q;

  // frame FSM, shift datapath and TX holding register
  always_comb begin
    state_d     = state_q;
    len16_d     = len16_q;
    cpol_d      = cpol_q;
    cpha_d      = cpha_q;
    cnt_d       = cnt_q;
    first_d     = first_q;
    pend_d      = pend_q;
    tx_sh_d     = tx_sh_q;
    rx_sh_d     = rx_sh_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    underrun_d  = 1'b0;
    abort_d     = 1'b0;
    flush_d     = flush_q;
    move        = 1'b0;
    move_len16  = len16_q;
    rx_new      = {rx_sh_q, mosi_s};
    cnt_inc     = cnt_q + 5'd1;
    unique case (state_q)
      WAIT_CS_HIGH: begin
        if (flush_q != FLUSH) flush_d = flush_q + 8'd1;
        else if (cs_s) state_d = IDLE;
      end
      IDLE: begin
        if (cs_fall) begin
          state_d    = ACTIVE;
          len16_d    = cfg_len;
          cpol_d     = cfg_cpol;
          cpha_d     = cfg_cpha;
          cnt_d      = 5'd0;
          pend_d     = 1'b0;
          first_d    = cfg_cpha;
          move       = 1'b1;
          move_len16 = cfg_len;
        end
      end
      ACTIVE: begin
        if (cs_rise) begin
          state_d = IDLE;
          cnt_d   = 5'd0;
          pend_d  = 1'b0;
          abort_d = (cnt_q != 5'd0);
        end else if (smp_edge) begin
          rx_sh_d = rx_new[14:0];
          if (cnt_inc == word_len(len16_q)) begin
            cnt_d      = 5'd0;
            pend_d     = 1'b1;
            rx_valid_d = 1'b1;
            rx_data_d  = len16_q ? rx_new : {8'h00, rx_new[7:0]};
          end else begin
            cnt_d = cnt_inc;
          end
        end else if (shf_edge) begin
          if (pend_q) begin
            pend_d = 1'b0;
            move   = 1'b1;
          end else if (first_q) begin
            first_d = 1'b0;
          end else begin
            tx_sh_d = {tx_sh_q[14:0], 1'b0};
          end
        end
      end
      default: state_d = WAIT_CS_HIGH;
    endcase
    if (move) begin
      if (hold_full_q) begin
        tx_sh_d     = move_len16 ? hold_q : {hold_q[7:0], 8'h00};
        hold_full_d = 1'b0;
      end else begin
        tx_sh_d    = move_len16 ? TX_FILL : {TX_FILL[15:8], 8'h00};
        underrun_d = 1'b1;
      end
    end
    if (accept) begin
      hold_d      = tx_data;
      hold_full_d = 1'b1;
    end
  end

  // state and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= WAIT_CS_HIGH;
      len16_q     <= 1'b0;
      cpol_q      <= 1'b0;
      cpha_q      <= 1'b0;
      cnt_q       <= 5'd0;
      first_q     <= 1'b0;
      pend_q      <= 1'b0;
      tx_sh_q     <= 16'h0000;
      rx_sh_q     <= 15'h0000;
      hold_q      <= 16'h0000;
      hold_full_q <= 1'b0;
      rx_data_q   <= 16'h0000;
      rx_valid_q  <= 1'b0;
      underrun_q  <= 1'b0;
      abort_q     <= 1'b0;
      flush_q     <= 8'd0;
      mosi_sync_q <= '0;
    end else begin
      state_q     <= state_d;
      len16_q     <= len16_d;
      cpol_q      <= cpol_d;
      cpha_q      <= cpha_d;
      cnt_q       <= cnt_d;
      first_q     <= first_d;
      pend_q      <= pend_d;
      tx_sh_q     <= tx_sh_d;
      rx_sh_q     <= rx_sh_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      underrun_q  <= underrun_d;
      abort_q     <= abort_d;
      flush_q     <= flush_d;
      mosi_sync_q <= mosi_sync_d;
    end
  end

  assign busy        = (state_q == ACTIVE);
  assign miso_oe     = busy;
  assign miso        = busy & tx_sh_q[15];
  assign tx_ready    = ~hold_full_q;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign tx_underrun = underrun_q;
  assign frame_abort = abort_q;

endmodule

// File: tb/tb_spi_follower.sv
// tb_spi_follower: directed SPI leader stimulus against spi_follower.
// Expected values are hand-computed per vector.
`timescale 1ns/1ps
module tb_spi_follower;

  localparam int HALF = 5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_len = 1'b0;
  logic        cfg_cpol = 1'b0;
  logic        cfg_cpha = 1'b0;
  logic        sclk = 1'b0;
  logic        cs_n = 1'b1;
  logic        mosi = 1'b0;
  logic        miso, miso_oe;
  logic [15:0] tx_data = 16'h0000;
  logic        tx_valid = 1'b0;
  logic        tx_ready;
  logic [15:0] rx_data;
  logic        rx_valid, busy, tx_underrun, frame_abort;

  int n_cmp = 0;
  int n_bad = 0;
  int rx_cnt = 0;
  int ur_cnt = 0;
  int ab_cnt = 0;
  int oe_cnt = 0;
  logic [15:0] rx_hist [0:63];
  logic [15:0] mi_acc;

  always #5 clk = ~clk;

  spi_follower #(
    .SYNC_STAGES (2),
    .TX_FILL     (16'hFFFF)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_len     (cfg_len),
    .cfg_cpol    (cfg_cpol),
    .cfg_cpha    (cfg_cpha),
    .sclk        (sclk),
    .cs_n        (cs_n),
    .mosi        (mosi),
    .miso        (miso),
    .miso_oe     (miso_oe),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .busy        (busy),
    .tx_underrun (tx_underrun),
    .frame_abort (frame_abort)
  );

  always @(negedge clk) begin
    if (rx_valid) begin
      rx_hist[rx_cnt % 64] = rx_data;
      rx_cnt++;
    end
    if (tx_underrun) ur_cnt++;
    if (frame_abort) ab_cnt++;
    if (miso_oe) oe_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_half();
    repeat (HALF) @(negedge clk);
  endtask

  task automatic push(input logic [15:0] w);
    int n = 0;
    while (!tx_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("push_timeout", 32'(tx_ready), 32'd1);
    tx_data  = w;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic word(input bit cpol, input bit cpha, input int len,
                      input int first, input int cnt,
                      input logic [15:0] mo);
    for (int i = first; i < first + cnt; i++) begin
      if (!cpha) begin
        mosi = mo[len-1-i];
        wait_half();
        sclk   = ~cpol;
        mi_acc = {mi_acc[14:0], miso};
        wait_half();
        sclk = cpol;
      end else begin
        sclk = ~cpol;
        mosi = mo[len-1-i];
        wait_half();
        sclk   = cpol;
        mi_acc = {mi_acc[14:0], miso};
        wait_half();
      end
    end
  endtask

  task automatic end_frame();
    wait_half();
    cs_n = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic setup(input bit len16, input bit cpol, input bit cpha);
    cfg_len  = len16;
    cfg_cpol = cpol;
    cfg_cpha = cpha;
    sclk     = cpol;
    repeat (6) @(negedge clk);
  endtask

  initial begin
    int b_rx, b_ur, b_ab, b_oe;
    logic [15:0] mi1;

    repeat (3) @(negedge clk);
    chk("rst_miso", 32'(miso), 32'd0);
    chk("rst_miso_oe", 32'(miso_oe), 32'd0);
    chk("rst_rx_data", 32'(rx_data), 32'd0);
    chk("rst_rx_valid", 32'(rx_valid), 32'd0);
    chk("rst_tx_ready", 32'(tx_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_underrun", 32'(tx_underrun), 32'd0);
    chk("rst_abort", 32'(frame_abort), 32'd0);
    rst = 1'b0;
    repeat (10) @(negedge clk);

    // mode 0, 8-bit
    setup(1'b0, 1'b0, 1'b0);
    push(16'h00A5);
    chk("m0_tx_ready_full", 32'(tx_ready), 32'd0);
    b_rx = rx_cnt;
    cs_n = 1'b0;
    repeat (4) @(negedge clk);
    chk("m0_busy", 32'(busy), 32'd1);
    chk("m0_miso_msb", 32'(miso), 32'd1);
    mi_acc = 16'h0;
    word(1'b0, 1'b0, 8, 0, 8, 16'h003C);
    end_frame();
    chk("m0_miso_bits", 32'(mi_acc[7:0]), 32'h00A5);
    chk("m0_rx_count", 32'(rx_cnt - b_rx), 32'd1);
    chk("m0_rx_data", 32'(rx_data), 32'h003C);
    chk("m0_busy_after", 32'(busy), 32'd0);

    // mode 3, 16-bit, back-to-back
    setup(1'b1, 1'b1, 1'b1);
    push(16'h1234);
    b_rx = rx_cnt;
    b_ur = ur_cnt;
    cs_n = 1'b0;
    repeat (4) @(negedge clk);
    push(16'hBEEF);
    mi_acc = 16'h0;
    word(1'b1, 1'b1, 16, 0, 16, 16'hCAFE);
    mi1    = mi_acc;
    mi_acc = 16'h0;
    word(1'b1, 1'b1, 16, 0, 16, 16'h0F0F);
    end_frame();
    chk("m3_miso_w0", 32'(mi1), 32'h1234);
    chk("m3_miso_w1", 32'(mi_acc), 32'hBEEF);
    chk("m3_rx_count", 32'(rx_cnt - b_rx), 32'd2);
    chk("m3_rx_w0", 32'(rx_hist[b_rx % 64]), 32'hCAFE);
    chk("m3_rx_w1", 32'(rx_hist[(b_rx + 1) % 64]), 32'h0F0F);
    chk("m3_no_underrun", 32'(ur_cnt - b_ur), 32'd0);

    // mode 1, 8-bit, underrun
    setup(1'b0, 1'b0, 1'b1);
    chk("ur_hold_empty", 32'(tx_ready), 32'd1);
    b_ur = ur_cnt;
    cs_n = 1'b0;
    repeat (4) @(negedge clk);
    mi_acc = 16'h0;
    word(1'b0, 1'b1, 8, 0, 8, 16'h005A);
    end_frame();
    chk("ur_miso_fill", 32'(mi_acc[7:0]), 32'h00FF);
    chk("ur_pulses", 32'(ur_cnt - b_ur), 32'd1);
    chk("ur_rx_data", 32'(rx_data), 32'h005A);

    // abort after 5 of 8 bits, holding register kept
    setup(1'b0, 1'b0, 1'b0);
    push(16'h0011);
    cs_n = 1'b0;
    repeat (4) @(negedge clk);
    push(16'h00C3);
    b_rx = rx_cnt;
    b_ab = ab_cnt;
    mi_acc = 16'h0;
    word(1'b0, 1'b0, 8, 0, 5, 16'h0096);
    end_frame();
    chk("ab_pulse", 32'(ab_cnt - b_ab), 32'd1);
    chk("ab_no_rx", 32'(rx_cnt - b_rx), 32'd0);
    chk("ab_busy", 32'(busy), 32'd0);
    chk("ab_hold_kept", 32'(tx_ready), 32'd0);
    cs_n = 1'b0;
    repeat (4) @(negedge clk);
    mi_acc = 16'h0;
    word(1'b0, 1'b0, 8, 0, 8, 16'h0096);
    end_frame();
    chk("ab_next_miso", 32'(mi_acc[7:0]), 32'h00C3);
    chk("ab_next_rx", 32'(rx_data), 32'h0096);
    chk("ab_next_no_abort", 32'(ab_cnt - b_ab), 32'd1);

    // reset mid-frame, mode 2
    setup(1'b0, 1'b1, 1'b0);
    push(16'h0055);
    cs_n = 1'b0;
    repeat (4) @(negedge clk);
    mi_acc = 16'h0;
    word(1'b1, 1'b0, 8, 0, 3, 16'h00FF);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("mrst_rx_data", 32'(rx_data), 32'd0);
    chk("mrst_tx_ready", 32'(tx_ready), 32'd1);
    chk("mrst_miso_oe", 32'(miso_oe), 32'd0);
    rst  = 1'b0;
    b_oe = oe_cnt;
    word(1'b1, 1'b0, 8, 3, 5, 16'h00FF);
    chk("mrst_oe_held_low", 32'(oe_cnt - b_oe), 32'd0);
    chk("mrst_busy", 32'(busy), 32'd0);
    end_frame();
    push(16'h00E7);
    cs_n = 1'b0;
    repeat (4) @(negedge clk);
    chk("mrst_oe_next", 32'(miso_oe), 32'd1);
    mi_acc = 16'h0;
    word(1'b1, 1'b0, 8, 0, 8, 16'h0081);
    end_frame();
    chk("mrst_next_miso", 32'(mi_acc[7:0]), 32'h00E7);
    chk("mrst_next_rx", 32'(rx_data), 32'h0081);

    // cfg_len change mid-frame is ignored
    setup(1'b0, 1'b0, 1'b0);
    push(16'h005A);
    b_rx = rx_cnt;
    b_ab = ab_cnt;
    cs_n = 1'b0;
    repeat (4) @(negedge clk);
    mi_acc = 16'h0;
    word(1'b0, 1'b0, 8, 0, 2, 16'h00C6);
    cfg_len = 1'b1;
    word(1'b0, 1'b0, 8, 2, 6, 16'h00C6);
    end_frame();
    cfg_len = 1'b0;
    chk("cfg_miso", 32'(mi_acc[7:0]), 32'h005A);
    chk("cfg_rx_count", 32'(rx_cnt - b_rx), 32'd1);
    chk("cfg_rx_data", 32'(rx_data), 32'h00C6);
    chk("cfg_no_abort", 32'(ab_cnt - b_ab), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/spi_follower.md
SPI_FOLLOWER -- requirements
Module: spi_follower

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2: flops in each pin synchronizer (minimum 2).
REQ-002 SHALL have parameter TX_FILL, default 16'hFFFF: word shifted out when no TX word is queued.
REQ-003 SHALL have port clk  in  1  system clock; all logic on rising edge.
REQ-004 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have ports cfg_len in 1 (0=8 bits, 1=16 bits), cfg_cpol in 1, cfg_cpha in 1.
REQ-006 SHALL have ports sclk in 1 and cs_n in 1: leader-driven SPI clock and active-low chip select, both asynchronous to clk.
REQ-007 SHALL have ports mosi in 1 (serial data in), miso out 1 (serial data out), miso_oe out 1 (tristate enable for the miso pad).
REQ-008 SHALL have ports tx_data in 16, tx_valid in 1, tx_ready out 1: CPU transmit handshake.
REQ-009 SHALL have ports rx_data out 16 and rx_valid out 1: received word plus a 1-cycle strobe.
REQ-010 SHALL have ports busy out 1, tx_underrun out 1, frame_abort out 1: status outputs; both error outputs are 1-cycle pulses.

Function
REQ-011 SHALL pass sclk, cs_n and mosi through SYNC_STAGES synchronizers; an sclk edge SHALL act on the clk cycle after it is detected at the synchronizer output (SYNC_STAGES+1 cycles of pin-to-action latency).
REQ-012 SHALL support sclk periods of 8 or more clk periods; slower sclk is unconstrained.
REQ-013 SHALL implement states IDLE, WAIT_CS_HIGH and ACTIVE; IDLE->ACTIVE on synchronized cs_n falling; ACTIVE->IDLE on cs_n rising.
REQ-014 SHALL latch cfg_len/cfg_cpol/cfg_cpha at the IDLE->ACTIVE transition; config changes during ACTIVE SHALL be ignored.
REQ-015 SHALL define the leading edge as rising when cpol=0 and falling when cpol=1; the trailing edge is the opposite.
REQ-016 cpha=0: MSB SHALL be on miso in the cycle ACTIVE is entered; sample mosi on leading edges; shift miso on trailing edges.
REQ-017 cpha=1: shift miso on leading edges, with the MSB presented at the first leading edge; sample mosi on trailing edges.
REQ-018 SHALL transfer MSB first; the bit counter counts samples, and the word completes at count 8 or 16.
REQ-019 On word completion, rx_data SHALL update and rx_valid SHALL pulse in the same cycle; rx_data holds until the next completion.
REQ-020 SHALL treat any further edges with cs_n still low after completion as a back-to-back word: the counter resets to 0 and the next TX word loads.
REQ-021 SHALL use a one-word TX holding register: tx_ready=1 when the register is empty; tx_valid&tx_ready writes it.
REQ-022 SHALL move the holding register into the shift register at ACTIVE entry and at each word completion.
REQ-023 If the holding register is empty at a move, SHALL load TX_FILL, truncated to the upper 8 bits of TX_FILL in 8-bit mode, and pulse tx_underrun.
REQ-024 If tx_valid is accepted in the same cycle as a move from an empty register, SHALL take the fill word and write the new word to the holding register.
REQ-025 If cs_n rises with 0 < count < length, SHALL discard the partial word, give no rx_valid, pulse frame_abort, and keep the holding-register contents.
REQ-026 SHALL drive miso_oe=1 only in ACTIVE; in all other states miso_oe=0 and miso=0.
REQ-027 SHALL drive busy=1 in ACTIVE and 0 otherwise.
REQ-028 8-bit mode: SHALL transmit tx_data[7:0] and place the received byte in rx_data[7:0] with rx_data[15:8]=0.

Reset
REQ-029 On rst assertion, SHALL asynchronously drive all of the following: state WAIT_CS_HIGH; miso=0, miso_oe=0; rx_data=0, rx_valid=0; tx_ready=1 with the holding register empty; busy=0, tx_underrun=0, frame_abort=0; bit counter 0.
REQ-030 Reset SHALL clear synchronizers to the idle level (cs_n=1, sclk=0).
REQ-031 WAIT_CS_HIGH SHALL move to IDLE only after synchronized cs_n reads 1, so a frame in progress at reset release is never joined mid-word.

Structure
REQ-032 Package spi_pkg SHALL hold the state enumeration and the length constants LEN8=8 and LEN16=16 shared with the existing SPI controller.
REQ-033 Sub-module spi_sync_edge SHALL implement one synchronizer plus rise/fall pulse outputs, instantiated for sclk and cs_n; mosi uses a plain synchronizer.

Verification
REQ-034 Mode 0, 8-bit: tx 8'hA5 queued, leader sends 8'h3C -> miso bits 1,0,1,0,0,1,0,1; rx_data=16'h003C with one rx_valid pulse.
REQ-035 Mode 3, 16-bit, back-to-back: tx 16'h1234 then 16'hBEEF, leader sends 16'hCAFE, 16'h0F0F under one cs_n low -> two rx_valid pulses with those values; miso carries 1234 then BEEF.
REQ-036 Underrun: no tx queued, mode 1, 8-bit -> miso shifts 8'hFF, tx_underrun pulses once at ACTIVE entry.
REQ-037 Abort: cs_n rises after 5 of 8 bits -> frame_abort pulses, no rx_valid, busy=0; the next full frame is received correctly.
REQ-038 Reset mid-frame at bit 3 (mode 2), cs_n held low -> miso_oe=0 until cs_n goes high; the following frame transfers correctly.
REQ-039 Config change mid-frame (cfg_len 0->1 after bit 2) -> the frame completes as 8-bit.
